// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port data memory behind a valid/ready request and
// response channel, with byte/half/word/double accesses and load extension.
// Optional build macro DMEM_MISALIGN_CHECK_EN: misaligned accesses fault
// instead of being aligned down.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. Once
// raised, rsp_valid, rsp_rdata and rsp_err stay constant until that transfer.
module data_memory_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            dbg_state_o
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = OFF_W + IDX_W;
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   we_q;
    logic [AW-1:0]          addr_q;
    logic [1:0]             size_q;
    logic                   uns_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   err_q;
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic                   accept, commit, mem_we;
    logic                   cur_we, cur_uns;
    logic [AW-1:0]          cur_addr;
    logic [1:0]             cur_size;
    logic [DATA_WIDTH-1:0]  cur_wdata;
    logic [IDX_W-1:0]       idx;
    logic [OFF_W-1:0]       off_raw, off, size_mask;
    logic [2:0]             mask3;
    logic                   illegal, misalign, fault;
    logic [DATA_WIDTH-1:0]  word, shifted, load_val, rdata_d, wdata_sh, wr_word;
    logic                   sign;
    int                     nbits, nbytes, offi;
    logic                   unused_addr;

    // Upper address bits only alias onto the array; they are intentionally dropped.
    assign unused_addr = ^req_addr[31:AW];

    assign req_ready   = (state_q == ST_IDLE) && rst_n;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign dbg_state_o = state_q;
    assign accept      = req_valid && req_ready;

    // Next-state logic; commit marks the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(LATENCY - 2)) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Effective request: live inputs on the accept edge, latched copy afterwards.
    always_comb begin
        cur_we    = (state_q == ST_IDLE) ? req_we           : we_q;
        cur_addr  = (state_q == ST_IDLE) ? req_addr[AW-1:0] : addr_q;
        cur_size  = (state_q == ST_IDLE) ? req_size         : size_q;
        cur_uns   = (state_q == ST_IDLE) ? req_unsigned     : uns_q;
        cur_wdata = (state_q == ST_IDLE) ? req_wdata        : wdata_q;
    end

    // Address decode, fault detection, load extraction and store merge.
    always_comb begin
        idx     = cur_addr[OFF_W +: IDX_W];
        off_raw = cur_addr[OFF_W-1:0];
        case (cur_size)
            2'd0:    begin mask3 = 3'd0; nbits = 8;  nbytes = 1; end
            2'd1:    begin mask3 = 3'd1; nbits = 16; nbytes = 2; end
            2'd2:    begin mask3 = 3'd3; nbits = 32; nbytes = 4; end
            default: begin mask3 = 3'd7; nbits = 64; nbytes = 8; end
        endcase
        size_mask = mask3[OFF_W-1:0];
        illegal   = (cur_size == 2'd3) && (DATA_WIDTH == 32);
`ifdef DMEM_MISALIGN_CHECK_EN
        misalign  = |(off_raw & size_mask);
        off       = off_raw;
`else
        misalign  = 1'b0;
        off       = off_raw & ~size_mask;
`endif
        fault     = illegal || misalign;
        offi      = int'(off);

        word    = mem_q[idx];
        shifted = word >> (8 * offi);
        case (cur_size)
            2'd0:    sign = shifted[7];
            2'd1:    sign = shifted[15];
            default: sign = shifted[31];
        endcase
        load_val = shifted;
        if (nbits < DATA_WIDTH) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (i >= nbits) load_val[i] = cur_uns ? 1'b0 : sign;
            end
        end
        rdata_d = (fault || cur_we) ? '0 : load_val;

        wdata_sh = cur_wdata << (8 * offi);
        wr_word  = word;
        for (int b = 0; b < NB; b++) begin
            if (b >= offi && b < offi + nbytes) wr_word[8*b +: 8] = wdata_sh[8*b +: 8];
        end
        mem_we = commit && cur_we && !fault && rst_n;
    end

    // Control state, request latch and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr[AW-1:0];
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                rdata_q <= rdata_d;
                err_q   <= fault;
            end
        end
    end

    // Memory array: no reset, contents survive rst_n.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= wr_word;
    end

endmodule
